// File: rtl/i2s_audio_tx.sv
// I2S master transmitter: generates BCK/LRCK from the board clock and serialises
// one stereo PCM pair per 64-BCK Philips frame out of a one-pair holding register.
module i2s_audio_tx #(
    parameter int CLK_DIV  = 8,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic [SAMPLE_W-1:0] left_i,
    input  logic [SAMPLE_W-1:0] right_i,
    input  logic                sample_valid_i,
    output logic                sample_ready_o,
    output logic                underflow_o,
    output logic                i2s_bck_o,
    output logic                i2s_lrck_o,
    output logic                i2s_data_o
);
    localparam int              DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0]      L_LAST   = 6'(SAMPLE_W);
    localparam logic [5:0]      R_FIRST  = 6'd33;
    localparam logic [5:0]      R_LAST   = 6'(32 + SAMPLE_W);

    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic                bck_q, bck_d;
    logic                lrck_q, lrck_d;
    logic                data_q, data_d;
    logic                underflow_q, underflow_d;
    logic                hold_empty_q, hold_empty_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [SAMPLE_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic [SAMPLE_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic                accept;
    logic                fall;

    always_comb begin
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bck_d        = bck_q;
        lrck_d       = lrck_q;
        data_d       = data_q;
        underflow_d  = 1'b0;
        hold_empty_d = hold_empty_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        last_l_d     = last_l_q;
        last_r_d     = last_r_q;
        shift_l_d    = shift_l_q;
        shift_r_d    = shift_r_q;

        accept = sample_valid_i & hold_empty_q;
        fall   = en_i & bck_q & (div_cnt_q == DIV_LAST);

        // The holding register never conflicts with a frame load: a load only
        // drains it when full, and an accept only happens when it is empty.
        if (accept) begin
            hold_l_d     = left_i;
            hold_r_d     = right_i;
            hold_empty_d = 1'b0;
        end

        if (!en_i) begin
            div_cnt_d = '0;
            bit_cnt_d = 6'd63;
            bck_d     = 1'b0;
            lrck_d    = 1'b0;
            data_d    = 1'b0;
        end else begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                bck_d     = ~bck_q;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end

            if (fall) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                lrck_d    = bit_cnt_d[5];
                data_d    = 1'b0;
                if (bit_cnt_d == 6'd0) begin
                    if (!hold_empty_q) begin
                        last_l_d     = hold_l_q;
                        last_r_d     = hold_r_q;
                        hold_empty_d = 1'b1;
                    end else begin
                        underflow_d = 1'b1;
                    end
                    shift_l_d = last_l_d;
                    shift_r_d = last_r_d;
                end else if (bit_cnt_d <= L_LAST) begin
                    data_d    = shift_l_q[SAMPLE_W-1];
                    shift_l_d = shift_l_q << 1;
                end else if (bit_cnt_d >= R_FIRST && bit_cnt_d <= R_LAST) begin
                    data_d    = shift_r_q[SAMPLE_W-1];
                    shift_r_d = shift_r_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= 6'd63;
            bck_q        <= 1'b0;
            lrck_q       <= 1'b0;
            data_q       <= 1'b0;
            underflow_q  <= 1'b0;
            hold_empty_q <= 1'b1;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            last_l_q     <= '0;
            last_r_q     <= '0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bck_q        <= bck_d;
            lrck_q       <= lrck_d;
            data_q       <= data_d;
            underflow_q  <= underflow_d;
            hold_empty_q <= hold_empty_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            last_l_q     <= last_l_d;
            last_r_q     <= last_r_d;
            shift_l_q    <= shift_l_d;
            shift_r_q    <= shift_r_d;
        end
    end

    assign sample_ready_o = hold_empty_q;
    assign underflow_o    = underflow_q;
    assign i2s_bck_o      = bck_q;
    assign i2s_lrck_o     = lrck_q;
    assign i2s_data_o     = data_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: a timing/queue reference model predicts
// which pair each frame carries; the DUT's serial output is captured per slot.
module tb_i2s_audio_tx;
    localparam int CLK_DIV = 8;
    localparam int SW      = 16;
    localparam int BCK_P   = 2 * CLK_DIV;
    localparam int T0      = 2 * CLK_DIV;
    localparam int FRAME   = 128 * CLK_DIV;

    logic          clk;
    logic          reset, en, sample_valid;
    logic [SW-1:0] left, right;
    logic          sample_ready, underflow, bck, lrck, data;

    int checks = 0;
    int errors = 0;

    int            m_t, m_uf_cnt;
    bit            m_full, m_acc;
    logic [SW-1:0] m_hl, m_hr, m_ll, m_lr;

    logic [63:0] obs_d[8];
    logic [63:0] obs_lr[8];
    int          fall_t, uf_cnt, nz_cnt;
    bit          prev_bck;
    int          obs_acc[$];

    i2s_audio_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_W(SW)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .left_i(left), .right_i(right), .sample_valid_i(sample_valid),
        .sample_ready_o(sample_ready), .underflow_o(underflow),
        .i2s_bck_o(bck), .i2s_lrck_o(lrck), .i2s_data_o(data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected 64-slot data word for a frame: bit s is the level driven in slot s.
    function automatic logic [63:0] exp_bits(input logic [SW-1:0] l, input logic [SW-1:0] r);
        logic [63:0] v;
        v = '0;
        for (int k = 1; k <= SW; k++) begin
            v |= 64'((l >> (SW - k)) & 1'b1) << k;
            v |= 64'((r >> (SW - k)) & 1'b1) << (32 + k);
        end
        return v;
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < 8; i++) begin
            obs_d[i]  = '0;
            obs_lr[i] = '0;
        end
        fall_t   = -1;
        uf_cnt   = 0;
        nz_cnt   = 0;
        prev_bck = 1'b0;
        m_uf_cnt = 0;
        obs_acc.delete();
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_full = 1'b0;
        m_acc  = 1'b0;
        m_hl   = '0;
        m_hr   = '0;
        m_ll   = '0;
        m_lr   = '0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        en           = 1'b0;
        sample_valid = 1'b0;
        left         = '0;
        right        = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        clear_obs();
    endtask

    // One clock: advance the reference model with the inputs the DUT sees at
    // this edge, then record what the DUT drives.
    task automatic step();
        bit pre_acc;
        int f, s;
        pre_acc = sample_ready && sample_valid;
        @(posedge clk);
        m_acc = sample_valid && !m_full;
        if (!en) begin
            m_t = 0;
        end else begin
            m_t++;
            if (m_t >= T0 && (m_t - T0) % FRAME == 0) begin
                if (m_full) begin
                    m_ll   = m_hl;
                    m_lr   = m_hr;
                    m_full = 1'b0;
                end else begin
                    m_uf_cnt++;
                end
            end
        end
        if (m_acc) begin
            m_hl   = left;
            m_hr   = right;
            m_full = 1'b1;
        end
        #1;
        if (pre_acc) obs_acc.push_back(m_t);
        if (underflow) uf_cnt++;
        if (!en && (bck || lrck || data)) nz_cnt++;
        if (prev_bck && !bck && fall_t < 0) fall_t = m_t;
        prev_bck = bck;
        if (en && m_t >= T0 && (m_t - T0) % BCK_P == CLK_DIV) begin
            s = ((m_t - T0) / BCK_P) % 64;
            f = (m_t - T0) / FRAME;
            if (f < 8) begin
                obs_d[f]  |= 64'(data) << s;
                obs_lr[f] |= 64'(lrck) << s;
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        en           = 1'b0;
        sample_valid = 1'b0;
        left         = '0;
        right        = '0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bck !== 1'b0)          begin errors++; $display("FAIL reset_bck got %b want 0", bck); end
        if (lrck !== 1'b0)         begin errors++; $display("FAIL reset_lrck got %b want 0", lrck); end
        if (data !== 1'b0)         begin errors++; $display("FAIL reset_data got %b want 0", data); end
        if (underflow !== 1'b0)    begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", sample_ready); end
        reset = 1'b0;
    endtask

    task automatic test_frame();
        do_reset();
        en           = 1'b1;
        sample_valid = 1'b1;
        left         = 16'h8001;
        right        = 16'h7FFE;
        while (m_t < T0 + FRAME + 8) step();
        checks += 5;
        if (fall_t != T0) begin errors++; $display("FAIL first_fall got %0d want %0d", fall_t, T0); end
        if (obs_d[0] !== 64'h0000_FFFC_0001_0002)
            begin errors++; $display("FAIL frame_literal got %h want 0000fffc00010002", obs_d[0]); end
        if (obs_d[0] !== exp_bits(16'h8001, 16'h7FFE))
            begin errors++; $display("FAIL frame_model got %h want %h", obs_d[0], exp_bits(16'h8001, 16'h7FFE)); end
        if (obs_lr[0] !== 64'hFFFF_FFFF_0000_0000)
            begin errors++; $display("FAIL lrck_slots got %h want ffffffff00000000", obs_lr[0]); end
        if (uf_cnt != 0) begin errors++; $display("FAIL frame_underflow got %0d want 0", uf_cnt); end
    endtask

    task automatic test_underflow();
        logic [SW-1:0] pl, pr;
        do_reset();
        pl           = SW'($urandom_range(1, 65535));
        pr           = SW'($urandom_range(1, 65535));
        en           = 1'b1;
        sample_valid = 1'b1;
        left         = pl;
        right        = pr;
        step();
        sample_valid = 1'b0;
        while (m_t < T0 + 4 * FRAME - 1) step();
        checks += 2;
        if (uf_cnt != 3)   begin errors++; $display("FAIL uf_pulses got %0d want 3", uf_cnt); end
        if (obs_acc.size() != 1) begin errors++; $display("FAIL uf_accepts got %0d want 1", obs_acc.size()); end
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (obs_d[f] !== exp_bits(pl, pr))
                begin errors++; $display("FAIL uf_repeat frame %0d got %h want %h", f, obs_d[f], exp_bits(pl, pr)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] bl, br, el, er;
        int rdy_cnt;
        do_reset();
        bl           = SW'($urandom);
        br           = SW'($urandom);
        rdy_cnt      = 0;
        en           = 1'b1;
        sample_valid = 1'b1;
        left         = bl;
        right        = br;
        while (m_t < T0 + 5 * FRAME - 1) begin
            step();
            if (m_acc) begin
                left  = left + 1'b1;
                right = right - 1'b1;
            end
            if (m_t >= T0 + 2 * FRAME && m_t < T0 + 3 * FRAME && sample_ready) rdy_cnt++;
        end
        checks += 3;
        if (uf_cnt != 0)   begin errors++; $display("FAIL b2b_underflow got %0d want 0", uf_cnt); end
        if (rdy_cnt != 1)  begin errors++; $display("FAIL b2b_ready_cycles got %0d want 1", rdy_cnt); end
        if (obs_acc.size() != 6) begin errors++; $display("FAIL b2b_accepts got %0d want 6", obs_acc.size()); end
        for (int i = 2; i < obs_acc.size(); i++) begin
            checks++;
            if (obs_acc[i] - obs_acc[i-1] != FRAME)
                begin errors++; $display("FAIL b2b_interval %0d got %0d want %0d", i, obs_acc[i] - obs_acc[i-1], FRAME); end
        end
        for (int f = 0; f < 5; f++) begin
            el = bl + SW'(f);
            er = br - SW'(f);
            checks++;
            if (obs_d[f] !== exp_bits(el, er))
                begin errors++; $display("FAIL b2b_frame %0d got %h want %h", f, obs_d[f], exp_bits(el, er)); end
        end
    endtask

    task automatic test_collide();
        logic [SW-1:0] al, ar, bl, br;
        do_reset();
        al           = SW'($urandom_range(1, 65535));
        ar           = SW'($urandom_range(1, 65535));
        bl           = ~al;
        br           = ~ar;
        en           = 1'b1;
        sample_valid = 1'b1;
        left         = al;
        right        = ar;
        step();
        sample_valid = 1'b0;
        while (m_t < T0 + FRAME - 1) step();
        left         = bl;
        right        = br;
        sample_valid = 1'b1;
        step();
        checks += 2;
        if (underflow !== 1'b1)    begin errors++; $display("FAIL collide_uf got %b want 1", underflow); end
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL collide_ready got %b want 0", sample_ready); end
        sample_valid = 1'b0;
        while (m_t < T0 + 3 * FRAME - 1) step();
        checks += 3;
        if (obs_d[1] !== exp_bits(al, ar))
            begin errors++; $display("FAIL collide_old got %h want %h", obs_d[1], exp_bits(al, ar)); end
        if (obs_d[2] !== exp_bits(bl, br))
            begin errors++; $display("FAIL collide_new got %h want %h", obs_d[2], exp_bits(bl, br)); end
        if (uf_cnt != m_uf_cnt || uf_cnt != 1)
            begin errors++; $display("FAIL collide_uf_count got %0d want 1", uf_cnt); end
    endtask

    task automatic test_enable();
        logic [SW-1:0] al, ar, bl, br;
        do_reset();
        al           = SW'($urandom_range(1, 65535));
        ar           = SW'($urandom_range(1, 65535));
        bl           = al ^ 16'h5A5A;
        br           = ar ^ 16'hA5A5;
        en           = 1'b1;
        sample_valid = 1'b1;
        left         = al;
        right        = ar;
        step();
        left  = bl;
        right = br;
        while (m_t < T0 + 1) step();
        sample_valid = 1'b0;
        while (m_t < T0 + 20 * BCK_P) step();
        en = 1'b0;
        repeat (100) step();
        checks += 2;
        if (nz_cnt != 0) begin errors++; $display("FAIL en_low_outputs got %0d nonzero cycles want 0", nz_cnt); end
        if (sample_ready !== !m_full)
            begin errors++; $display("FAIL en_low_ready got %b want %b", sample_ready, !m_full); end
        en = 1'b1;
        clear_obs();
        while (m_t < T0 + FRAME - 1) step();
        checks += 3;
        if (fall_t != T0) begin errors++; $display("FAIL en_restart_fall got %0d want %0d", fall_t, T0); end
        if (obs_d[0] !== exp_bits(bl, br))
            begin errors++; $display("FAIL en_held_pair got %h want %h", obs_d[0], exp_bits(bl, br)); end
        if (uf_cnt != 0) begin errors++; $display("FAIL en_restart_uf got %0d want 0", uf_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        en           = 1'b1;
        sample_valid = 1'b1;
        left         = SW'($urandom_range(1, 65535));
        right        = SW'($urandom_range(1, 65535));
        step();
        left  = ~left;
        right = ~right;
        while (m_t < T0 + 1) step();
        sample_valid = 1'b0;
        while (m_t < T0 + 40 * BCK_P + CLK_DIV) step();
        checks += 2;
        if (lrck !== 1'b1)         begin errors++; $display("FAIL pre_reset_lrck got %b want 1", lrck); end
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_ready got %b want 0", sample_ready); end
        #2;
        reset = 1'b1;
        #1;
        checks += 4;
        if (bck !== 1'b0)          begin errors++; $display("FAIL async_bck got %b want 0", bck); end
        if (lrck !== 1'b0)         begin errors++; $display("FAIL async_lrck got %b want 0", lrck); end
        if (data !== 1'b0)         begin errors++; $display("FAIL async_data got %b want 0", data); end
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b want 1", sample_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        clear_obs();
        while (m_t < T0 + FRAME - 1) step();
        checks += 3;
        if (uf_cnt != 1)        begin errors++; $display("FAIL post_reset_uf got %0d want 1", uf_cnt); end
        if (obs_d[0] !== '0)    begin errors++; $display("FAIL post_reset_data got %h want 0", obs_d[0]); end
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", sample_ready); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        clear_obs();
        test_reset();
        test_frame();
        test_underflow();
        test_back_to_back();
        test_collide();
        test_enable();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
